// File: rtl/int_pipe_scheduler_if.sv
// Issue/writeback bus between the integer issue queue and int_pipe_scheduler.
// Signals (three pipes, one lane each):
//   flush             pipeline flush, kills all in-flight work
//   issue_valid       per pipe, a uop is issued this cycle
//   issue_fu          per pipe, 00 ALU, 01 BR, 10 MUL, 11 DIV
//   issue_rd_valid    per pipe, the uop writes an integer destination
//   issue_rd_index    per pipe, destination PRF index
//   ex_busy           per pipe, the pipe must not receive an issue this cycle
//   ctb_valid         per pipe, tag broadcast valid
//   ctb_prf_int_index per pipe, broadcast tag
//   sched_err         sticky illegal-issue flag
// master = issue queue side, slave = scheduler side.
interface int_pipe_scheduler_if #(
  parameter int unsigned PRF_W = 7
) ();
  logic                  flush;
  logic [2:0]            issue_valid;
  logic [2:0][1:0]       issue_fu;
  logic [2:0]            issue_rd_valid;
  logic [2:0][PRF_W-1:0] issue_rd_index;
  logic [2:0]            ex_busy;
  logic [2:0]            ctb_valid;
  logic [2:0][PRF_W-1:0] ctb_prf_int_index;
  logic                  sched_err;

  modport master (
    output flush, issue_valid, issue_fu, issue_rd_valid, issue_rd_index,
    input  ex_busy, ctb_valid, ctb_prf_int_index, sched_err
  );

  modport slave (
    input  flush, issue_valid, issue_fu, issue_rd_valid, issue_rd_index,
    output ex_busy, ctb_valid, ctb_prf_int_index, sched_err
  );
endinterface

// File: rtl/int_pipe_scheduler.sv
// Occupancy and writeback-timing tracker for the three integer execution pipes.
//   Pipe 0: ALU/BR, pipe 1: ALU/pipelined IMUL, pipe 2: ALU/iterative IDIV.
// Drives ex_busy back to the issue queue, generates the common tag bus in the
// exact writeback cycle of each result and flags illegal issues (sticky).
// Ports:
//   i_clock   sole clock
//   i_reset   synchronous, active-high reset
//   if_sched  issue/writeback bus (slave modport), see int_pipe_scheduler_if
module int_pipe_scheduler #(
  parameter int unsigned MUL_LAT         = 3,
  parameter int unsigned DIV_LAT         = 12,
  parameter int unsigned ISSUE_WIDTH_INT = 3,
  parameter int unsigned PRF_W           = 7
) (
  input logic                  i_clock,
  input logic                  i_reset,
  int_pipe_scheduler_if.slave  if_sched
);

  localparam logic [1:0] FuAlu = 2'b00;
  localparam logic [1:0] FuMul = 2'b10;
  localparam logic [1:0] FuDiv = 2'b11;
  localparam int unsigned CntW = $clog2(DIV_LAT);

  typedef enum logic {StIdle, StBusy} state_e;

  logic [ISSUE_WIDTH_INT-1:0] w_legal;
  logic [ISSUE_WIDTH_INT-1:0] w_busy;
  logic [ISSUE_WIDTH_INT-1:0] w_block;
  logic [ISSUE_WIDTH_INT-1:0] w_accept;
  logic                       w_err_set;

  // Reservation shift registers for pipes 0 and 1: slot k = result on the ctb k cycles from now.
  logic [1:0][MUL_LAT-1:0]            r_res, w_res_d;
  logic [1:0][MUL_LAT-1:0]            r_rd, w_rd_d;
  logic [1:0][MUL_LAT-1:0][PRF_W-1:0] r_tag, w_tag_d;

  state_e          r_state, w_state_d;
  logic            w_div_busy;
  logic [CntW-1:0] r_cnt;
  logic [PRF_W-1:0] r_div_tag;
  logic            r_div_rd;
  logic            r_ctb2_valid;
  logic [PRF_W-1:0] r_ctb2_idx;
  logic            r_sched_err;

  // ---------------------------------------------------------------------------
  // Issue acceptance
  // ---------------------------------------------------------------------------
  always_comb begin
    w_legal[0] = (if_sched.issue_fu[0] == FuAlu) | (if_sched.issue_fu[0] == 2'b01);
    w_legal[1] = (if_sched.issue_fu[1] == FuAlu) | (if_sched.issue_fu[1] == FuMul);
    w_legal[2] = (if_sched.issue_fu[2] == FuAlu) | (if_sched.issue_fu[2] == FuDiv);

    w_busy[0] = i_reset;
    w_busy[1] = r_res[1][1];
    w_busy[2] = w_div_busy;

    // Pipe 1 busy only means slot 0 is taken next cycle; a MUL lands further out and never collides.
    w_block[0] = w_busy[0];
    w_block[1] = w_busy[1] & (if_sched.issue_fu[1] != FuMul);
    w_block[2] = w_busy[2];

    w_accept  = if_sched.issue_valid & w_legal & ~w_block & {ISSUE_WIDTH_INT{~if_sched.flush}};
    // Issues arriving with flush are discarded silently.
    w_err_set = ~if_sched.flush & (|(if_sched.issue_valid & ~(w_legal & ~w_block)));
  end

  // ---------------------------------------------------------------------------
  // Pipes 0/1: reservation shift registers
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_res_d[p] = r_res[p] >> 1;
      w_rd_d[p]  = r_rd[p] >> 1;
      w_tag_d[p] = r_tag[p] >> PRF_W;
      if (w_accept[p]) begin
        if (if_sched.issue_fu[p] == FuMul) begin
          w_res_d[p][MUL_LAT-1] = 1'b1;
          w_rd_d[p][MUL_LAT-1]  = if_sched.issue_rd_valid[p];
          w_tag_d[p][MUL_LAT-1] = if_sched.issue_rd_index[p];
        end else begin
          w_res_d[p][0] = 1'b1;
          w_rd_d[p][0]  = if_sched.issue_rd_valid[p];
          w_tag_d[p][0] = if_sched.issue_rd_index[p];
        end
      end
    end
    if (if_sched.flush) begin
      w_res_d = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_res <= '0;
      r_rd  <= '0;
      r_tag <= '0;
    end else begin
      r_res <= w_res_d;
      r_rd  <= w_rd_d;
      r_tag <= w_tag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipe 2: divider FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: if (w_accept[2] && (if_sched.issue_fu[2] == FuDiv)) w_state_d = StBusy;
      StBusy: if (r_cnt == CntW'(1)) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (if_sched.flush) begin
      w_state_d = StIdle;
    end
  end

  always_comb begin
    w_div_busy = (r_state == StBusy);
  end

  // Divider counter, latched DIV tag and the pipe 2 ctb register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_div_tag    <= '0;
      r_div_rd     <= 1'b0;
      r_ctb2_valid <= 1'b0;
      r_ctb2_idx   <= '0;
    end else if (if_sched.flush) begin
      r_cnt        <= '0;
      r_ctb2_valid <= 1'b0;
    end else begin
      r_ctb2_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_accept[2]) begin
            if (if_sched.issue_fu[2] == FuDiv) begin
              r_cnt     <= CntW'(DIV_LAT - 1);
              r_div_tag <= if_sched.issue_rd_index[2];
              r_div_rd  <= if_sched.issue_rd_valid[2];
            end else begin
              r_ctb2_valid <= if_sched.issue_rd_valid[2];
              r_ctb2_idx   <= if_sched.issue_rd_index[2];
            end
          end
        end
        StBusy: begin
          r_cnt <= r_cnt - CntW'(1);
          // Loading on cnt == 1 puts the DIV broadcast exactly DIV_LAT cycles after issue.
          if (r_cnt == CntW'(1)) begin
            r_ctb2_valid <= r_div_rd;
            r_ctb2_idx   <= r_div_tag;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sched_err <= 1'b0;
    end else if (w_err_set) begin
      r_sched_err <= 1'b1;
    end
  end

  assign if_sched.ex_busy              = w_busy;
  assign if_sched.ctb_valid            = {r_ctb2_valid, r_res[1][0] & r_rd[1][0],
                                          r_res[0][0] & r_rd[0][0]};
  assign if_sched.ctb_prf_int_index[0] = r_tag[0][0];
  assign if_sched.ctb_prf_int_index[1] = r_tag[1][0];
  assign if_sched.ctb_prf_int_index[2] = r_ctb2_idx;
  assign if_sched.sched_err            = r_sched_err;

endmodule
